// File: rtl/dac_sweep_sequencer.sv
// dac_sweep_sequencer
// Steps the DAC driver phase increment from a start value to a stop value,
// holding each value for a programmable dwell. One configuration is accepted
// over a valid/ready handshake while idle. A sweep can be one-shot, which ends
// with a Done pulse, or looping, which runs until Abort.
module dac_sweep_sequencer #(
    parameter int DWELL_W = 24,
    parameter int PHASE_W = 9
) (
    input  logic               clk_100MHz,
    input  logic               Rst,
    input  logic               Cfg_Valid,
    output logic               Cfg_Ready,
    input  logic [1:0]         Cfg_Mode,
    input  logic [PHASE_W-1:0] Cfg_Phase_Start,
    input  logic [PHASE_W-1:0] Cfg_Phase_Stop,
    input  logic [PHASE_W-1:0] Cfg_Step,
    input  logic [DWELL_W-1:0] Cfg_Dwell,
    input  logic               Cfg_Loop,
    input  logic               Start,
    input  logic               Abort,
    output logic               DAC_En,
    output logic [1:0]         Wave_Mode,
    output logic [PHASE_W-1:0] Phase,
    output logic               Busy,
    output logic               Step_Tick,
    output logic               Done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;

    // Latched configuration
    logic [1:0]         r_mode;
    logic [PHASE_W-1:0] r_start;
    logic [PHASE_W-1:0] r_stop;
    logic [PHASE_W-1:0] r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_loop;

    // Sweep progress and registered outputs
    logic [DWELL_W-1:0] r_cnt;
    logic               r_dac_en;
    logic [1:0]         r_wave_mode;
    logic [PHASE_W-1:0] r_phase;
    logic               r_busy;
    logic               r_step_tick;
    logic               r_done;

    logic               w_cfg_take;
    logic [1:0]         w_mode_use;
    logic [PHASE_W-1:0] w_start_use;
    logic               w_go;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_dwell_end;
    logic [PHASE_W:0]   w_next;
    logic               w_over;

    // Handshake and start qualification. A config arriving in the same cycle
    // as Start must be the one this sweep uses, so mode and start value
    // bypass the config registers on that cycle.
    always_comb begin
        Cfg_Ready   = (r_state == S_IDLE) & ~Rst;
        w_cfg_take  = Cfg_Valid & Cfg_Ready;
        w_mode_use  = w_cfg_take ? Cfg_Mode        : r_mode;
        w_start_use = w_cfg_take ? Cfg_Phase_Start : r_start;
        w_go        = (r_state == S_IDLE) & Start & ~Abort & (w_mode_use != 2'd0);
    end

    // Dwell expiry and next phase. The sum is one bit wider than Phase so an
    // overshoot past the top of the range is seen as "past stop" and never
    // wraps back into range.
    always_comb begin
        w_dwell_eff = (r_dwell == '0) ? DWELL_ONE : r_dwell;
        w_dwell_end = (r_cnt >= w_dwell_eff);
        w_next      = {1'b0, r_phase} + {1'b0, r_step};
        w_over      = (w_next > {1'b0, r_stop});
    end

    // Sequencer state, configuration capture and registered outputs
    always_ff @(posedge clk_100MHz) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register here samples pre-edge values, independent of statement order.
        if (Rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_start     <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_dwell     <= DWELL_ONE;
            r_loop      <= 1'b0;
            r_cnt       <= DWELL_ONE;
            r_dac_en    <= 1'b0;
            r_wave_mode <= 2'd0;
            r_phase     <= '0;
            r_busy      <= 1'b0;
            r_step_tick <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_step_tick <= 1'b0;
            r_done      <= 1'b0;

            if (w_cfg_take) begin
                r_mode  <= Cfg_Mode;
                r_start <= Cfg_Phase_Start;
                r_stop  <= Cfg_Phase_Stop;
                r_step  <= Cfg_Step;
                r_dwell <= Cfg_Dwell;
                r_loop  <= Cfg_Loop;
            end

            if (Abort) begin
                r_state     <= S_IDLE;
                r_dac_en    <= 1'b0;
                r_wave_mode <= 2'd0;
                r_phase     <= '0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_go) begin
                            r_state     <= S_RUN;
                            r_dac_en    <= 1'b1;
                            r_busy      <= 1'b1;
                            r_wave_mode <= w_mode_use;
                            r_phase     <= w_start_use;
                            r_cnt       <= DWELL_ONE;
                        end
                    end
                    S_RUN: begin
                        if (!w_dwell_end) begin
                            r_cnt <= r_cnt + DWELL_ONE;
                        end else if (r_step == '0) begin
                            // Fixed tone: hold the start value until Abort
                            r_cnt <= DWELL_ONE;
                        end else if (!w_over) begin
                            r_phase     <= w_next[PHASE_W-1:0];
                            r_step_tick <= 1'b1;
                            r_cnt       <= DWELL_ONE;
                        end else if (r_loop) begin
                            r_phase     <= r_start;
                            r_step_tick <= 1'b1;
                            r_cnt       <= DWELL_ONE;
                        end else begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_dac_en    <= 1'b0;
                            r_busy      <= 1'b0;
                            r_wave_mode <= 2'd0;
                            r_phase     <= '0;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Output ports come straight from their registers
    always_comb begin
        DAC_En    = r_dac_en;
        Wave_Mode = r_wave_mode;
        Phase     = r_phase;
        Busy      = r_busy;
        Step_Tick = r_step_tick;
        Done      = r_done;
    end

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// tb_dac_sweep_sequencer
// Directed test of dac_sweep_sequencer with hand-computed expected values.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_dac_sweep_sequencer;

    localparam int DWELL_W = 24;
    localparam int PHASE_W = 9;

    logic               clk_100MHz = 1'b0;
    logic               Rst = 1'b1;
    logic               Cfg_Valid = 1'b0;
    logic               Cfg_Ready;
    logic [1:0]         Cfg_Mode = 2'd0;
    logic [PHASE_W-1:0] Cfg_Phase_Start = '0;
    logic [PHASE_W-1:0] Cfg_Phase_Stop = '0;
    logic [PHASE_W-1:0] Cfg_Step = '0;
    logic [DWELL_W-1:0] Cfg_Dwell = '0;
    logic               Cfg_Loop = 1'b0;
    logic               Start = 1'b0;
    logic               Abort = 1'b0;
    logic               DAC_En;
    logic [1:0]         Wave_Mode;
    logic [PHASE_W-1:0] Phase;
    logic               Busy;
    logic               Step_Tick;
    logic               Done;

    int n_checks = 0;
    int n_fail   = 0;

    dac_sweep_sequencer #(.DWELL_W(DWELL_W), .PHASE_W(PHASE_W)) dut (
        .clk_100MHz     (clk_100MHz),
        .Rst            (Rst),
        .Cfg_Valid      (Cfg_Valid),
        .Cfg_Ready      (Cfg_Ready),
        .Cfg_Mode       (Cfg_Mode),
        .Cfg_Phase_Start(Cfg_Phase_Start),
        .Cfg_Phase_Stop (Cfg_Phase_Stop),
        .Cfg_Step       (Cfg_Step),
        .Cfg_Dwell      (Cfg_Dwell),
        .Cfg_Loop       (Cfg_Loop),
        .Start          (Start),
        .Abort          (Abort),
        .DAC_En         (DAC_En),
        .Wave_Mode      (Wave_Mode),
        .Phase          (Phase),
        .Busy           (Busy),
        .Step_Tick      (Step_Tick),
        .Done           (Done)
    );

    // 100 MHz clock
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] mode, input int ps, input int pe,
                           input int st, input int dw, input logic lp);
        Cfg_Mode        = mode;
        Cfg_Phase_Start = PHASE_W'(ps);
        Cfg_Phase_Stop  = PHASE_W'(pe);
        Cfg_Step        = PHASE_W'(st);
        Cfg_Dwell       = DWELL_W'(dw);
        Cfg_Loop        = lp;
    endtask

    task automatic load(input logic [1:0] mode, input int ps, input int pe,
                        input int st, input int dw, input logic lp);
        set_cfg(mode, ps, pe, st, dw, lp);
        Cfg_Valid = 1'b1;
        step();
        Cfg_Valid = 1'b0;
    endtask

    // Pulse Start for one cycle; on return the view is cycle N+1
    task automatic go();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic abort_now();
        Abort = 1'b1;
        step();
        Abort = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " en"},    DAC_En, 0);
        check({tag, " busy"},  Busy, 0);
        check({tag, " phase"}, Phase, 0);
        check({tag, " mode"},  Wave_Mode, 0);
        check({tag, " done"},  Done, 0);
        check({tag, " tick"},  Step_Tick, 0);
    endtask

    initial begin
        int ticks;

        // ---------------- reset ----------------
        step();
        step();
        check("rst ready", Cfg_Ready, 0);
        check_idle("rst");
        Rst = 1'b0;
        #1;
        check("ready after rst", Cfg_Ready, 1);

        // Start with cleared mode 0 is ignored
        go();
        check("mode0 busy", Busy, 0);
        check("mode0 ready", Cfg_Ready, 1);

        // ---------------- test 1: basic one-shot sweep ----------------
        load(2'd1, 10, 40, 10, 3, 1'b0);
        go();
        ticks = 0;
        for (int k = 1; k <= 12; k++) begin
            check("t1 phase", Phase, 10 + 10 * ((k - 1) / 3));
            check("t1 en", DAC_En, 1);
            check("t1 mode", Wave_Mode, 1);
            check("t1 tick", Step_Tick, (k == 4 || k == 7 || k == 10) ? 1 : 0);
            check("t1 done early", Done, 0);
            if (Step_Tick) ticks++;
            step();
        end
        check("t1 tick count", ticks, 3);
        check("t1 done", Done, 1);
        check("t1 done en", DAC_En, 0);
        check("t1 done busy", Busy, 0);
        check("t1 done phase", Phase, 0);
        check("t1 done mode", Wave_Mode, 0);
        step();
        check_idle("t1 after");
        check("t1 ready", Cfg_Ready, 1);

        // ---------------- test 2: no wrap at top of range ----------------
        load(2'd2, 500, 511, 20, 2, 1'b0);
        go();
        check("t2 phase k1", Phase, 500);
        check("t2 mode", Wave_Mode, 2);
        step();
        check("t2 phase k2", Phase, 500);
        check("t2 done k2", Done, 0);
        step();
        check("t2 done", Done, 1);
        check("t2 phase end", Phase, 0);
        step();
        check("t2 ready", Cfg_Ready, 1);

        // ---------------- test 3: looping sweep and abort ----------------
        load(2'd3, 5, 15, 5, 1, 1'b1);
        go();
        for (int k = 1; k <= 7; k++) begin
            check("t3 phase", Phase, (k % 3 == 1) ? 5 : (k % 3 == 2) ? 10 : 15);
            check("t3 tick", Step_Tick, (k > 1) ? 1 : 0);
            check("t3 done", Done, 0);
            step();
        end
        abort_now();
        check_idle("t3 abort");
        check("t3 ready", Cfg_Ready, 1);
        // Config retained after abort
        go();
        check("t3 retained phase", Phase, 5);
        check("t3 retained mode", Wave_Mode, 3);
        abort_now();
        check("t3 abort2 busy", Busy, 0);

        // Abort together with Start in IDLE: stays idle
        Abort = 1'b1;
        Start = 1'b1;
        step();
        Abort = 1'b0;
        Start = 1'b0;
        check("idle abort+start busy", Busy, 0);

        // ---------------- test 4: fixed tone, dwell 0 ----------------
        load(2'd1, 7, 100, 0, 0, 1'b0);
        go();
        for (int k = 1; k <= 1000; k++) begin
            check("t4 phase", Phase, 7);
            check("t4 busy", Busy, 1);
            check("t4 done", Done, 0);
            step();
        end
        Abort = 1'b1;
        Start = 1'b1;
        step();
        Abort = 1'b0;
        Start = 1'b0;
        check_idle("t4 abort");
        step();
        check("t4 stays idle", Busy, 0);
        check("t4 no done", Done, 0);

        // ---------------- test 5: config during RUN, same-cycle capture ----------------
        load(2'd1, 3, 200, 1, 5, 1'b0);
        go();
        set_cfg(2'd2, 99, 150, 7, 2, 1'b0);
        Cfg_Valid = 1'b1;
        #1;
        check("t5 ready in run", Cfg_Ready, 0);
        step();
        Cfg_Valid = 1'b0;
        check("t5 mode unchanged", Wave_Mode, 1);
        check("t5 phase unchanged", Phase, 3);
        abort_now();
        go();
        check("t5 old cfg mode", Wave_Mode, 1);
        check("t5 old cfg phase", Phase, 3);
        abort_now();
        set_cfg(2'd3, 50, 60, 10, 1, 1'b0);
        Cfg_Valid = 1'b1;
        Start     = 1'b1;
        step();
        Cfg_Valid = 1'b0;
        Start     = 1'b0;
        check("t5 new mode", Wave_Mode, 3);
        check("t5 new phase", Phase, 50);
        step();
        check("t5 next phase", Phase, 60);
        check("t5 next tick", Step_Tick, 1);
        step();
        check("t5 done", Done, 1);
        step();

        // ---------------- test 6: reset mid-dwell ----------------
        load(2'd2, 20, 100, 5, 10, 1'b0);
        go();
        step();
        step();
        check("t6 running", Phase, 20);
        Rst = 1'b1;
        step();
        check_idle("t6 rst");
        Rst = 1'b0;
        step();
        check("t6 no done", Done, 0);
        go();
        check("t6 mode0 busy", Busy, 0);
        check("t6 mode0 phase", Phase, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
